// File: rtl/id_ex_operand_stage_pkg.sv
// Shared types and ALU op codes for the ID/EX operand stage.
// Struct widths follow the default stage parameters.
package riscv_ex_pkg;

    localparam int XLEN  = 32;
    localparam int OP_W  = 4;
    localparam int REG_W = 5;

    localparam logic [OP_W-1:0] ALU_AND   = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OR    = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD   = 4'b0010;
    localparam logic [OP_W-1:0] ALU_XOR   = 4'b0011;
    localparam logic [OP_W-1:0] ALU_SLL   = 4'b0100;
    localparam logic [OP_W-1:0] ALU_SRL   = 4'b0101;
    localparam logic [OP_W-1:0] ALU_SUB   = 4'b0110;
    localparam logic [OP_W-1:0] ALU_SLT   = 4'b0111;
    localparam logic [OP_W-1:0] ALU_SLTU  = 4'b1000;
    localparam logic [OP_W-1:0] ALU_BR    = 4'b1001;
    localparam logic [OP_W-1:0] ALU_PASSA = 4'b1010;
    localparam logic [OP_W-1:0] ALU_SRA   = 4'b1100;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic             a_sel;
        logic             b_sel;
        logic [OP_W-1:0]  op;
        logic             blt;
        logic             bgt;
        logic             bltu;
        logic             bgeu;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
    } id_ex_t;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-to-execute handshake bundle: valid/ready plus decoded fields.
// master = ID stage, slave = ID/EX operand stage.
interface id_ex_operand_stage_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
);

    logic                     id_valid;
    logic                     id_ready;
    logic [REG_ADDR_W-1:0]    id_rs1;
    logic [REG_ADDR_W-1:0]    id_rs2;
    logic [REG_ADDR_W-1:0]    id_rd;
    logic [DATA_WIDTH-1:0]    id_rs1_data;
    logic [DATA_WIDTH-1:0]    id_rs2_data;
    logic [DATA_WIDTH-1:0]    id_imm;
    logic [DATA_WIDTH-1:0]    id_pc;
    logic                     id_a_sel;
    logic                     id_b_sel;
    logic [OPCODE_LENGTH-1:0] id_operation;
    logic                     id_blt;
    logic                     id_bgt;
    logic                     id_bltu;
    logic                     id_bgeu;
    logic                     id_reg_write;
    logic                     id_mem_read;
    logic                     id_mem_write;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd,
        output id_rs1_data, id_rs2_data, id_imm, id_pc,
        output id_a_sel, id_b_sel, id_operation,
        output id_blt, id_bgt, id_bltu, id_bgeu,
        output id_reg_write, id_mem_read, id_mem_write,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd,
        input  id_rs1_data, id_rs2_data, id_imm, id_pc,
        input  id_a_sel, id_b_sel, id_operation,
        input  id_blt, id_bgt, id_bltu, id_bgeu,
        input  id_reg_write, id_mem_read, id_mem_write,
        output id_ready
    );

endinterface

// File: rtl/id_ex_operand_stage_fwd.sv
// Per-operand forwarding mux: MEM beats WB beats stored register data.
// x0 is never forwarded.
module fwd_mux
    import riscv_ex_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [DATA_WIDTH-1:0] mem_result,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic [DATA_WIDTH-1:0] wb_result,
    output logic [DATA_WIDTH-1:0] value
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_reg_write & (mem_rd != '0) & (mem_rd == rs);
    assign wb_hit  = wb_reg_write & (wb_rd != '0) & (wb_rd == rs);

    always_comb begin
        value = data;
        if (mem_hit)
            value = mem_result;
        else if (wb_hit)
            value = wb_result;
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register, forwarding and operand select feeding the ALU.
// Optional perf counters enabled by defining ID_EX_PERF_EN.
module id_ex_operand_stage
    import riscv_ex_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    id_ex_operand_stage_if.slave     id,
    input  logic                     ex_ready,
    input  logic                     flush,
    input  logic [REG_ADDR_W-1:0]    mem_rd,
    input  logic [REG_ADDR_W-1:0]    wb_rd,
    input  logic                     mem_reg_write,
    input  logic                     wb_reg_write,
    input  logic [DATA_WIDTH-1:0]    mem_result,
    input  logic [DATA_WIDTH-1:0]    wb_result,
    output logic                     ex_valid,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     BLT,
    output logic                     BGT,
    output logic                     BLTU,
    output logic                     BGEU,
    output logic [REG_ADDR_W-1:0]    ex_rd,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic                     load_use_stall,
    output logic [31:0]              stall_count,
    output logic [31:0]              flush_count
);

    id_ex_t q;
    id_ex_t d;

    logic                  hazard;
    logic                  wb_fix1;
    logic                  wb_fix2;
    logic [DATA_WIDTH-1:0] fwd1;
    logic [DATA_WIDTH-1:0] fwd2;

    assign hazard = q.valid & q.mem_read & (q.rd != '0) & id.id_valid
                  & ((q.rd == id.id_rs1) | (q.rd == id.id_rs2));

    assign load_use_stall = hazard & ex_ready & ~flush;
    assign id.id_ready    = ex_ready & ~hazard;

    assign wb_fix1 = wb_reg_write & (wb_rd != '0) & (wb_rd == q.rs1);
    assign wb_fix2 = wb_reg_write & (wb_rd != '0) & (wb_rd == q.rs2);

    always_comb begin
        d = q;
        if (flush) begin
            d = '0;
        end else if (!ex_ready) begin
            // WB retires while we hold; keep its value once it leaves the pipe
            if (wb_fix1)
                d.rs1_data = wb_result;
            if (wb_fix2)
                d.rs2_data = wb_result;
        end else if (hazard) begin
            d = '0;
        end else if (id.id_valid) begin
            d.valid     = 1'b1;
            d.rs1       = id.id_rs1;
            d.rs2       = id.id_rs2;
            d.rd        = id.id_rd;
            d.rs1_data  = id.id_rs1_data;
            d.rs2_data  = id.id_rs2_data;
            d.imm       = id.id_imm;
            d.pc        = id.id_pc;
            d.a_sel     = id.id_a_sel;
            d.b_sel     = id.id_b_sel;
            d.op        = id.id_operation;
            d.blt       = id.id_blt;
            d.bgt       = id.id_bgt;
            d.bltu      = id.id_bltu;
            d.bgeu      = id.id_bgeu;
            d.reg_write = id.id_reg_write;
            d.mem_read  = id.id_mem_read;
            d.mem_write = id.id_mem_write;
        end else begin
            d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else
            q <= d;
    end

    fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd1 (
        .rs            (q.rs1),
        .data          (q.rs1_data),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .value         (fwd1)
    );

    fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd2 (
        .rs            (q.rs2),
        .data          (q.rs2_data),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .value         (fwd2)
    );

    // Bubbles present AND of zeros so the ALU result is 0
    assign ex_valid      = q.valid;
    assign SrcA          = !q.valid ? '0 : (q.a_sel ? q.pc : fwd1);
    assign SrcB          = !q.valid ? '0 : (q.b_sel ? q.imm : fwd2);
    assign Operation     = q.valid ? q.op : ALU_AND;
    assign BLT           = q.valid & q.blt;
    assign BGT           = q.valid & q.bgt;
    assign BLTU          = q.valid & q.bltu;
    assign BGEU          = q.valid & q.bgeu;
    assign ex_rd         = q.rd;
    assign ex_reg_write  = q.valid & q.reg_write;
    assign ex_mem_read   = q.valid & q.mem_read;
    assign ex_mem_write  = q.valid & q.mem_write;
    assign ex_store_data = fwd2;

`ifdef ID_EX_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (load_use_stall)
                stall_q <= stall_q + 32'd1;
            if (flush & q.valid)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule
